// File: rtl/uart_prog_loader.sv
// Purpose: loads a length-prefixed byte stream from a UART receiver into instruction memory, then releases the core.
// Latency: imem_we fires one cycle after the 4th byte of a word; cpu_rst_n rises one cycle after entering DONE.
// Backpressure: none; every rx_valid byte is taken in a loading state, and an idle gap of TIMEOUT_CYCLES aborts the load.
module uart_prog_loader #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          MAX_WORDS      = 1024,
    parameter int          TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_rst_n,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] words_loaded,
    output logic [15:0] bad_op_cnt
);

    localparam int             TCW     = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TCW-1:0] TC_LAST = TCW'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0]    MAXW    = 17'(MAX_WORDS);

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        DONE,
        ERROR
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [7:0]     len_lo;
    logic [15:0]    len;
    logic [15:0]    len_full;
    logic [1:0]     byte_idx;
    logic [23:0]    wbuf;
    logic [TCW-1:0] tcnt;
    logic           start_acc;
    logic           byte_acc;
    logic           word_cap;
    logic           tmo;

    function automatic logic op_ok(input logic [6:0] op);
        case (op)
            7'b0000011, 7'b0010011, 7'b0010111, 7'b0100011,
            7'b0110011, 7'b0110111, 7'b1100011, 7'b1101111: op_ok = 1'b1;
            default:                                        op_ok = 1'b0;
        endcase
    endfunction

    assign busy     = (state == LEN_LO) || (state == LEN_HI) || (state == DATA);
    assign done     = (state == DONE);
    assign err      = (state == ERROR);
    assign len_full = {rx_data, len_lo};
    assign tmo      = (tcnt == TC_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A byte arriving in the timeout cycle takes priority over the abort.
    always_comb begin
        state_nxt = state;
        start_acc = 1'b0;
        byte_acc  = 1'b0;
        word_cap  = 1'b0;
        case (state)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_nxt = LEN_LO;
                end
            end
            LEN_LO: begin
                if (rx_valid) begin
                    byte_acc  = 1'b1;
                    state_nxt = LEN_HI;
                end else if (tmo) begin
                    state_nxt = ERROR;
                end
            end
            LEN_HI: begin
                if (rx_valid) begin
                    byte_acc = 1'b1;
                    if (len_full == 16'd0) begin
                        state_nxt = DONE;
                    end else if ({1'b0, len_full} > MAXW) begin
                        state_nxt = ERROR;
                    end else begin
                        state_nxt = DATA;
                    end
                end else if (tmo) begin
                    state_nxt = ERROR;
                end
            end
            DATA: begin
                if (rx_valid) begin
                    byte_acc = 1'b1;
                    if (byte_idx == 2'd3) begin
                        word_cap = 1'b1;
                        if ((words_loaded + 16'd1) == len) begin
                            state_nxt = DONE;
                        end
                    end
                end else if (tmo) begin
                    state_nxt = ERROR;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_we      <= 1'b0;
            imem_addr    <= BASE_ADDR;
            imem_wdata   <= 32'd0;
            cpu_rst_n    <= 1'b0;
            words_loaded <= 16'd0;
            bad_op_cnt   <= 16'd0;
            len_lo       <= 8'd0;
            len          <= 16'd0;
            byte_idx     <= 2'd0;
            wbuf         <= 24'd0;
            tcnt         <= '0;
        end else begin
            imem_we   <= word_cap;
            // Held low through the start cycle so the core drops reset right after a new load is accepted.
            cpu_rst_n <= (state == DONE) && !start_acc;

            if (start_acc) begin
                words_loaded <= 16'd0;
                bad_op_cnt   <= 16'd0;
                byte_idx     <= 2'd0;
                tcnt         <= '0;
            end else if (busy) begin
                if (byte_acc || tmo) begin
                    tcnt <= '0;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
            end

            if (byte_acc) begin
                case (state)
                    LEN_LO: len_lo <= rx_data;
                    LEN_HI: len    <= len_full;
                    DATA: begin
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0:    wbuf[7:0]   <= rx_data;
                            2'd1:    wbuf[15:8]  <= rx_data;
                            2'd2:    wbuf[23:16] <= rx_data;
                            default: wbuf        <= wbuf;
                        endcase
                    end
                    default: ;
                endcase
            end

            if (word_cap) begin
                imem_wdata   <= {rx_data, wbuf};
                imem_addr    <= BASE_ADDR + {14'd0, words_loaded, 2'b00};
                words_loaded <= words_loaded + 16'd1;
                if (!op_ok(wbuf[6:0]) && (bad_op_cnt != 16'hFFFF)) begin
                    bad_op_cnt <= bad_op_cnt + 16'd1;
                end
            end
        end
    end

endmodule
